// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one external 32x32 signed multiplier between two requesters.
// Holds operands for LAT cycles, samples the product and returns the selected half over valid/ready.
module mul_sched #(
    parameter int unsigned LAT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_hi,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_hi,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       last;
    logic       id_q;
    logic       hi_q;
    logic       grant0, grant1;
    logic       accept;
    logic       retire;

    // last names the previous winner; on contention the other requester goes next
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last);
        grant1 = req1_valid & (~req0_valid | ~last);
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign retire     = (state == RESP) & rsp_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)      state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            last      <= 1'b1;
            id_q      <= 1'b0;
            hi_q      <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'd0;
            op_count  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a <= req1_ready ? req1_a  : req0_a;
                        mul_b <= req1_ready ? req1_b  : req0_b;
                        hi_q  <= req1_ready ? req1_hi : req0_hi;
                        id_q  <= req1_ready;
                        last  <= req1_ready;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data  <= hi_q ? mul_c[63:32] : mul_c[31:0];
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (retire) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Shares one 32x32 signed combinational multiplier (64-bit product, fixed settle time) between two requesters.
- Arbitrates round-robin, holds operands stable for LAT cycles, captures the product and returns the selected 32-bit half with a requester ID over a valid/ready response channel.
- Sits between the issuing pipelines and the multiplier datapath; one operation in flight at a time.

Parameters:
- LAT, 6, cycles the operands are held stable on mul_a/mul_b before mul_c is sampled. Legal range is 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  32  requester 0 multiplicand (two's complement)
- req0_b  input  32  requester 0 multiplier (two's complement)
- req0_hi  input  1  1 = return product[63:32]; 0 = return product[31:0]
- req1_valid, req1_ready, req1_a, req1_b, req1_hi  same as requester 0, for requester 1
- mul_a  output  32  operand A driven to the multiplier
- mul_b  output  32  operand B driven to the multiplier
- mul_c  input  64  signed product from the multiplier
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester that issued the response
- rsp_data  output  32  selected product half
- busy  output  1  high when the state is not IDLE
- op_count  output  16  count of completed responses; wraps from 0xFFFF to 0

Behaviour:
- States:
  - IDLE: no operation in flight.
  - WAIT: down-counter cnt (4 bits) running.
  - RESP: rsp_valid held high.
- Reset (asynchronous, on rst_n low):
  - State goes to IDLE; cnt=0.
  - mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, busy=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - Reset mid-operation discards the operation; no response is produced.
- Grant (combinational, IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last.
  - reqN_ready = (state==IDLE) & grantN.
  - Both ready signals are 0 in WAIT and RESP.
  - At most one ready is high in any cycle.
- Accept edge (reqN_valid & reqN_ready):
  - Load mul_a/mul_b from the granted requester.
  - Latch hi and id; last=id; cnt=LAT-1; go to WAIT.
- WAIT:
  - mul_a/mul_b stay stable.
  - If cnt!=0, decrement.
  - If cnt==0, rsp_data = hi ? mul_c[63:32] : mul_c[31:0]; rsp_id = id; rsp_valid=1; go to RESP.
  - Operands are therefore stable for exactly LAT cycles before sampling.
  - rsp_valid first rises at the edge LAT cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_data stay stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, op_count+=1, go to IDLE.
  - mul_a/mul_b keep their last values in IDLE.
- Throughput: at most one operation per LAT+2 cycles. No acceptance in the cycle a response retires; the next accept occurs in IDLE the following cycle.
- Requester-side inputs are ignored outside the accept edge. A requester dropping valid before it is granted is legal.
- The product is taken from mul_c verbatim. The block performs no sign handling.
- op_count wraps silently.

Test Plan:
- req0 a=3, b=4, hi=0, LAT=6, rsp_ready=1 -> req0_ready in cycle 0; rsp_valid rises 6 edges after accept with rsp_id=0, rsp_data=12; op_count=1.
- req1 a=0xFFFFFFFF (-1), b=1, hi=1 -> rsp_id=1, rsp_data=0xFFFFFFFF. Repeat with hi=0 -> 0xFFFFFFFF.
- a=0x80000000, b=0x80000000: hi=1 -> 0x40000000; hi=0 -> 0x00000000.
- Both requesters valid continuously for 4 operations -> grant order 0,1,0,1. Responses alternate rsp_id. Ready is never high during WAIT/RESP.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_data/rsp_id stable, busy=1, no req accepted. rsp_ready=1 then returns IDLE and op_count increments once.
- rst_n pulsed low during WAIT (cnt=3) -> immediately busy=0, mul_a=0, rsp_valid=0, no response afterwards. The next req0 behaves as in the first scenario.
